// File: rtl/led_pattern_gen.sv
// led_pattern_gen: drives WIDTH LEDs from a programmable prescaler tick.
// Modes: binary up/down counter, Gray counter, bouncing one-hot scan,
// and Galois LFSR. Supports synchronous preload and tick/wrap strobes
// for chaining several generators.
module led_pattern_gen #(
  parameter int               WIDTH = 8,
  parameter int               DIV_W = 24,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] leds,
  output logic             tick,
  output logic             wrap
);

  localparam logic [1:0] MODE_BIN  = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_SCAN = 2'd2;
  localparam logic [1:0] MODE_LFSR = 2'd3;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ST_ONE   = WIDTH'(1);
  localparam logic [DIV_W-1:0] PRE_ONE  = DIV_W'(1);

  // Registered state
  logic [DIV_W-1:0] r_pre;
  logic [WIDTH-1:0] r_st;
  logic [1:0]       r_mode_q;
  logic             r_sdir;    // scan direction, 1 = toward MSB
  logic [WIDTH-1:0] r_leds;
  logic             r_tick;
  logic             r_wrap;

  // Next-state values
  logic [DIV_W-1:0] w_pre_next;
  logic [WIDTH-1:0] w_st_next;
  logic             w_sdir_next;
  logic [WIDTH-1:0] w_leds_next;
  logic             w_tick_next;
  logic             w_wrap_next;

  logic             w_fire;
  logic             w_mode_chg;
  logic             w_load_onehot;

  // Starting state of each mode's sequence
  function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
    case (m)
      MODE_SCAN: seed_of = ST_ONE;
      MODE_LFSR: seed_of = ALL_ONES;
      default:   seed_of = '0;
    endcase
  endfunction

  // ">=" so that lowering div mid-period fires at once instead of waiting
  // for the prescaler to wrap around
  assign w_fire        = en && (r_pre >= div);
  assign w_mode_chg    = (mode != r_mode_q);
  assign w_load_onehot = (load_val != '0) && ((load_val & (load_val - ST_ONE)) == '0);

  // Next-state logic: load beats mode change, which beats a tick step
  always_comb begin
    w_pre_next  = r_pre;
    w_st_next   = r_st;
    w_sdir_next = r_sdir;
    w_tick_next = 1'b0;
    w_wrap_next = 1'b0;
    if (load) begin
      w_pre_next = '0;
      case (mode)
        MODE_LFSR: w_st_next = (load_val == '0) ? ALL_ONES : load_val;
        MODE_SCAN: begin
          // A loaded scan position always starts moving toward the MSB
          w_st_next   = w_load_onehot ? load_val : ST_ONE;
          w_sdir_next = 1'b1;
        end
        default:   w_st_next = load_val;
      endcase
    end else if (w_mode_chg) begin
      w_pre_next  = '0;
      w_st_next   = seed_of(mode);
      w_sdir_next = 1'b1;
    end else if (w_fire) begin
      w_pre_next  = '0;
      w_tick_next = 1'b1;
      case (r_mode_q)
        MODE_SCAN: begin
          if (r_sdir) begin
            if (r_st[WIDTH-1]) begin
              w_st_next   = r_st >> 1;
              w_sdir_next = 1'b0;
            end else begin
              w_st_next = r_st << 1;
            end
          end else begin
            if (r_st[0]) begin
              w_st_next   = r_st << 1;
              w_sdir_next = 1'b1;
            end else begin
              w_st_next = r_st >> 1;
            end
          end
          w_wrap_next = (w_st_next == ST_ONE);
        end
        MODE_LFSR: begin
          w_st_next   = (r_st >> 1) ^ (r_st[0] ? TAPS : '0);
          w_wrap_next = (w_st_next == ALL_ONES);
        end
        default: begin
          if (dir) begin
            w_st_next   = r_st + ST_ONE;
            w_wrap_next = (r_st == ALL_ONES);
          end else begin
            w_st_next   = r_st - ST_ONE;
            w_wrap_next = (r_st == '0);
          end
        end
      endcase
    end else if (en) begin
      w_pre_next = r_pre + PRE_ONE;
    end
  end

  // LED pattern derived from the next state so it updates with st
  always_comb begin
    w_leds_next = w_st_next;
    if (mode == MODE_GRAY) begin
      w_leds_next = w_st_next ^ (w_st_next >> 1);
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre    <= '0;
      r_st     <= '0;
      r_mode_q <= MODE_BIN;
      r_sdir   <= 1'b1;
      r_leds   <= '0;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_pre    <= w_pre_next;
      r_st     <= w_st_next;
      r_mode_q <= mode;
      r_sdir   <= w_sdir_next;
      r_leds   <= w_leds_next;
      r_tick   <= w_tick_next;
      r_wrap   <= w_wrap_next;
    end
  end

  assign leds = r_leds;
  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed scenarios plus randomized traffic for
// led_pattern_gen (WIDTH=8), compared every cycle against a sequence-level
// reference model (counter value, scan position index, LFSR word).
module tb_led_pattern_gen;

  localparam int          W    = 8;
  localparam int          DW   = 24;
  localparam logic [7:0]  TAPS = 8'hB8;
  localparam int          SCAN_P = 2 * (W - 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic          dir;
  logic [DW-1:0] div;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  leds;
  logic          tick;
  logic          wrap;

  led_pattern_gen #(.WIDTH(W), .DIV_W(DW), .TAPS(TAPS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .div      (div),
    .load     (load),
    .load_val (load_val),
    .leds     (leds),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_cnt;    // BIN/GRAY counter value
  int         m_idx;    // SCAN position within its 2*(W-1) period
  logic [7:0] m_lfsr;
  int         m_pre;
  logic [1:0] m_mode;
  logic [7:0] exp_leds;
  logic       exp_tick;
  logic       exp_wrap;

  int n_ticks, n_wraps;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_leds();
    int pos;
    logic [7:0] c;
    c = 8'(m_cnt);
    case (m_mode)
      2'd0: return c;
      2'd1: return c ^ (c >> 1);
      2'd2: begin
        pos = (m_idx < W) ? m_idx : SCAN_P - m_idx;
        return 8'(1 << pos);
      end
      default: return m_lfsr;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_lfsr = 8'hFF; m_pre = 0; m_mode = 2'd0;
    exp_leds = 8'h00; exp_tick = 1'b0; exp_wrap = 1'b0;
  endtask

  // One clock of behaviour, from the current input values
  task automatic model_step();
    bit fire;
    fire = en && (m_pre >= int'(div));
    exp_tick = 1'b0;
    exp_wrap = 1'b0;
    if (load) begin
      m_pre = 0;
      case (mode)
        2'd0, 2'd1: m_cnt = int'(load_val);
        2'd2: begin
          m_idx = 0;
          if ($countones(load_val) == 1)
            for (int i = 0; i < W; i++) if (load_val[i]) m_idx = i;
        end
        default: m_lfsr = (load_val == 8'h00) ? 8'hFF : load_val;
      endcase
    end else if (mode != m_mode) begin
      m_pre = 0; m_cnt = 0; m_idx = 0; m_lfsr = 8'hFF;
    end else if (fire) begin
      m_pre = 0;
      exp_tick = 1'b1;
      case (mode)
        2'd0, 2'd1: begin
          if (dir) begin
            exp_wrap = (m_cnt == 255);
            m_cnt = (m_cnt + 1) % 256;
          end else begin
            exp_wrap = (m_cnt == 0);
            m_cnt = (m_cnt + 255) % 256;
          end
        end
        2'd2: begin
          m_idx = (m_idx + 1) % SCAN_P;
          exp_wrap = (m_idx == 0);
        end
        default: begin
          m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 8'h00);
          exp_wrap = (m_lfsr == 8'hFF);
        end
      endcase
    end else if (en) begin
      m_pre++;
    end
    m_mode = mode;
    exp_leds = model_leds();
  endtask

  // Advance one clock and compare outputs against the model
  task automatic cycle_chk();
    model_step();
    @(posedge clk);
    #1;
    check_val("leds", 32'(leds), 32'(exp_leds));
    check_val("tick", 32'(tick), 32'(exp_tick));
    check_val("wrap", 32'(wrap), 32'(exp_wrap));
    if (tick) n_ticks++;
    if (wrap) n_wraps++;
  endtask

  // Asynchronous reset pulse, checked before any clock edge
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_val("async_rst_leds", 32'(leds), 32'h0);
    check_val("async_rst_tick", 32'(tick), 32'h0);
    check_val("async_rst_wrap", 32'(wrap), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int         bitflip_bad;
  int         repeat_80;
  int         distinct;
  logic [7:0] prev;
  bit         seen [256];

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 2'd0; dir = 1'b1; div = '0;
    load = 1'b0; load_val = '0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_leds", 32'(leds), 32'h0);
    check_val("reset_tick", 32'(tick), 32'h0);
    check_val("reset_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;
    $display("reset: leds=%0h tick=%0b wrap=%0b", leds, tick, wrap);

    // BIN up, tick every 3 clocks, one wrap after 256 steps
    en = 1'b1; mode = 2'd0; dir = 1'b1; div = 24'd2;
    n_ticks = 0; n_wraps = 0;
    repeat (775) cycle_chk();
    check_val("bin_ticks", 32'(n_ticks), 32'd258);
    check_val("bin_wraps", 32'(n_wraps), 32'd1);
    $display("bin up div=2: ticks=%0d wraps=%0d", n_ticks, n_wraps);

    // GRAY down every clock: one LED bit changes per step
    mode = 2'd1; dir = 1'b0; div = '0;
    cycle_chk();
    check_val("gray_seed", 32'(leds), 32'h00);
    prev = leds; bitflip_bad = 0; n_wraps = 0;
    repeat (300) begin
      cycle_chk();
      if ($countones(leds ^ prev) != 1) bitflip_bad++;
      prev = leds;
    end
    check_val("gray_onebit", 32'(bitflip_bad), 32'd0);
    check_val("gray_wraps", 32'(n_wraps), 32'd2);
    $display("gray down: bad_steps=%0d wraps=%0d", bitflip_bad, n_wraps);

    // SCAN bounce: period 14, MSB LED never held twice
    mode = 2'd2;
    cycle_chk();
    check_val("scan_seed", 32'(leds), 32'h01);
    prev = leds; repeat_80 = 0; n_wraps = 0;
    repeat (56) begin
      cycle_chk();
      if (leds == 8'h80 && prev == 8'h80) repeat_80++;
      prev = leds;
    end
    check_val("scan_no_repeat", 32'(repeat_80), 32'd0);
    check_val("scan_wraps", 32'(n_wraps), 32'd4);
    $display("scan: wraps=%0d repeats=%0d", n_wraps, repeat_80);

    // LFSR: 255 distinct nonzero states then back to all-ones
    mode = 2'd3;
    cycle_chk();
    check_val("lfsr_seed", 32'(leds), 32'hFF);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct = 0; n_wraps = 0;
    repeat (255) begin
      cycle_chk();
      if (!seen[leds]) distinct++;
      seen[leds] = 1'b1;
    end
    check_val("lfsr_distinct", 32'(distinct), 32'd255);
    check_val("lfsr_no_zero", 32'(seen[0]), 32'd0);
    check_val("lfsr_back_ff", 32'(leds), 32'hFF);
    check_val("lfsr_wraps", 32'(n_wraps), 32'd1);
    load = 1'b1; load_val = 8'h00;
    cycle_chk();
    check_val("lfsr_load0", 32'(leds), 32'hFF);
    load = 1'b0;
    $display("lfsr: distinct=%0d wraps=%0d", distinct, n_wraps);

    // Lowering div mid-period fires next cycle; en=0 freezes everything
    mode = 2'd0; dir = 1'b1; div = 24'd1000;
    repeat (500) cycle_chk();
    div = 24'd10;
    cycle_chk();
    check_val("div_drop_tick", 32'(tick), 32'd1);
    repeat (5) cycle_chk();
    en = 1'b0;
    prev = leds; n_ticks = 0;
    repeat (50) cycle_chk();
    check_val("freeze_leds", 32'(leds), 32'(prev));
    check_val("freeze_ticks", 32'(n_ticks), 32'd0);
    en = 1'b1;
    repeat (12) cycle_chk();
    $display("div drop / freeze: leds=%0h", leds);

    // Load together with mode change and a prescaler fire
    div = '0;
    cycle_chk();
    mode = 2'd2; load = 1'b1; load_val = 8'h10;
    cycle_chk();
    check_val("load_prio_leds", 32'(leds), 32'h10);
    check_val("load_prio_tick", 32'(tick), 32'd0);
    load = 1'b0; mode = 2'd0;
    repeat (20) cycle_chk();
    do_reset();
    $display("load priority / async reset: leds=%0h", leds);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      en   = ($urandom_range(9) != 0);
      if ($urandom_range(49) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(19) == 0) dir = ~dir;
      if ($urandom_range(29) == 0) div = DW'($urandom_range(3));
      load = ($urandom_range(29) == 0);
      case ($urandom_range(2))
        0:       load_val = 8'($urandom);
        1:       load_val = 8'h00;
        default: load_val = 8'(1 << $urandom_range(7));
      endcase
      if ($urandom_range(999) == 0) begin
        @(negedge clk);
        do_reset();
      end else begin
        cycle_chk();
      end
    end
    load = 1'b0;
    $display("random traffic: 3000 cycles, leds=%0h", leds);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
